sha256_main: RTL and testbench
==============================

SHA256_MAIN -- requirements
Module: sha256_main

Interface
REQ-001 The block SHALL have no parameters; message capacity is fixed at one 512-bit SHA-256 block (max 55 message bytes).
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 Port list, in order:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-low reset.
- byte_rdy  input  1  data_in holds a valid message byte this cycle.
- byte_stop  input  1  end of message; start padding and hashing.
- data_in  input  8  message byte; the first byte accepted is the most significant byte of the message.
- overflow  output  1  message exceeded 55 bytes (sticky).
- out  output  256  digest; H0 is in out[255:224] and H7 is in out[31:0].
- o_valid  output  1  out holds the final digest (level, held).

Function
REQ-004 States: COLLECT, PAD, ROUNDS, FINAL, DONE, ERR.
- After reset the block SHALL be in COLLECT with byte count 0.
REQ-005 In COLLECT, on each rising clk edge with byte_rdy=1, the block SHALL store data_in at byte position count (big-endian within 32-bit words) and increment count.
- One byte is accepted per cycle, with no back-pressure.
REQ-006 In COLLECT, when byte_stop=1 is sampled, the block SHALL go to PAD.
- If byte_rdy=1 in the same cycle, that byte SHALL be accepted first and counted in the length.
REQ-007 In PAD (one cycle), the block SHALL build the padded block:
- byte 0x80 at position count;
- zeros up to byte 55;
- bytes 56..63 = 64-bit big-endian bit length (8*count).
- It SHALL then load the working variables a..h from H0..H7 (FIPS 180-4 initial values) and go to ROUNDS.
REQ-008 In ROUNDS, the block SHALL perform exactly one SHA-256 compression round per cycle for t=0..63.
- Wt SHALL come from a rolling 16-word schedule window (sigma0/sigma1 expansion for t>=16).
- Kt SHALL come from the standard 64-entry constant table.
- All additions are modulo 2^32.
REQ-009 In FINAL (one cycle), the block SHALL add a..h to H0..H7 (mod 2^32), drive out with the result, assert o_valid, and go to DONE.
REQ-010 The total latency from the cycle byte_stop is sampled to the first cycle o_valid=1 SHALL be 66 clock cycles (1 PAD + 64 ROUNDS + 1 FINAL).
REQ-011 In DONE, out and o_valid=1 SHALL be held stable, and byte_rdy and byte_stop SHALL be ignored until reset.
REQ-012 If byte_rdy=1 in COLLECT when count=55, the byte SHALL be discarded, overflow SHALL be set to 1, and the block SHALL go to ERR.
REQ-013 In ERR, overflow SHALL stay 1, o_valid SHALL stay 0, out SHALL stay 0, and all inputs SHALL be ignored until reset.
REQ-014 byte_stop with count=0 SHALL produce the digest of the empty message.
REQ-015 byte_rdy and byte_stop SHALL be ignored (including X values) while rst=0, and in every state other than COLLECT.
REQ-016 out SHALL read 0 in all states except FINAL and DONE.

Reset
REQ-017 When rst=0 at a rising edge, the block SHALL set the following, taking effect at that edge:
- out=0, o_valid=0, overflow=0, count=0;
- message buffer cleared;
- state=COLLECT.
REQ-018 A reset asserted during any state (including mid-ROUNDS) SHALL abort the operation with no residual effect on the next message.

Verification
REQ-019 Bytes 0x61,0x62,0x63 on consecutive cycles, then byte_stop -> 66 cycles later o_valid=1, out=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, overflow=0.
REQ-020 byte_stop with no bytes -> out=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, o_valid=1.
REQ-021 The 56-byte ASCII string "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", then byte_stop -> overflow=1 from the cycle after the 56th byte, o_valid stays 0 for 200 cycles, out=0.
REQ-022 "abc" with byte_stop and the final byte_rdy asserted in the same cycle as byte 0x63 -> same digest as REQ-019.
REQ-023 "abc" sent, rst=0 pulsed at round 30, then "abc" resent -> o_valid=0 and out=0 during reset; the second run gives the REQ-019 digest with correct latency.
REQ-024 After o_valid=1, further byte_rdy pulses and bytes -> out and o_valid remain unchanged.

Source files
------------

// File: rtl/sha256_main_if.sv
// sha256_main_if: byte-stream and digest signals of the single-block SHA-256 engine.
//   byte_rdy   master -> slave  data_in holds a valid message byte this cycle
//   byte_stop  master -> slave  end of message; start padding and hashing
//   data_in    master -> slave  message byte, first byte is the most significant
//   overflow   slave -> master  message exceeded 55 bytes (sticky)
//   out        slave -> master  digest, H0 in out[255:224], H7 in out[31:0]
//   o_valid    slave -> master  out holds the final digest
interface sha256_main_if;
  logic         byte_rdy;
  logic         byte_stop;
  logic [7:0]   data_in;
  logic         overflow;
  logic [255:0] out;
  logic         o_valid;

  modport master (
    output byte_rdy, byte_stop, data_in,
    input  overflow, out, o_valid
  );

  modport slave (
    input  byte_rdy, byte_stop, data_in,
    output overflow, out, o_valid
  );
endinterface

// File: rtl/sha256_main.sv
// sha256_main: hashes one message of up to 55 bytes into a SHA-256 digest.
// Bytes are collected one per cycle, padded into a single 512-bit block,
// compressed one round per cycle and the digest is held until reset.
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  sha256_main_if.slave (byte_rdy, byte_stop, data_in, overflow, out, o_valid)
//
// state   | meaning
// COLLECT | accepting message bytes, count = bytes stored
// PAD     | build the padded block, load a..h from the initial hash
// ROUNDS  | one compression round per cycle, t = 0..63
// FINAL   | add a..h into the initial hash, publish the digest
// DONE    | digest held, inputs ignored until reset
// ERR     | message too long, inputs ignored until reset
module sha256_main (
  input  logic         clk,
  input  logic         rst,
  sha256_main_if.slave bus
);

  typedef enum logic [2:0] {COLLECT, PAD, ROUNDS, FINAL, DONE, ERR} state_t;

  localparam logic [31:0] k_table [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] h_init [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t       state, state_next;
  logic [5:0]   count;
  logic [5:0]   rnd;
  logic [7:0]   msg_buf [55];
  logic [7:0]   pad_byte [64];
  logic [31:0]  blk [16];
  logic [31:0]  w [16];
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [31:0]  t1, t2, w_next;
  logic [255:0] out_q;
  logic         valid_q;
  logic         ovf_q;

  assign bus.out      = out_q;
  assign bus.o_valid  = valid_q;
  assign bus.overflow = ovf_q;

  // Unused buffer bytes are always zero (cleared at reset, written only
  // below count), so padding only has to place the 0x80 marker and length.
  always_comb begin
    for (int i = 0; i < 64; i++) pad_byte[i] = 8'h00;
    for (int i = 0; i < 55; i++) pad_byte[i] = msg_buf[i];
    pad_byte[count] = 8'h80;
    pad_byte[62]    = {7'b0, count[5]};
    pad_byte[63]    = {count[4:0], 3'b000};
    for (int i = 0; i < 16; i++)
      blk[i] = {pad_byte[4*i], pad_byte[4*i+1], pad_byte[4*i+2], pad_byte[4*i+3]};
  end

  // Window holds W[t..t+15]; w[0] is the current Wt and w_next is W[t+16].
  always_comb begin
    t1 = h + big_s1(e) + ((e & f) ^ (~e & g)) + k_table[rnd] + w[0];
    t2 = big_s0(a) + ((a & b) ^ (a & c) ^ (b & c));
    w_next = small_s1(w[14]) + w[9] + small_s0(w[1]) + w[0];
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= COLLECT;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: begin
        if (bus.byte_rdy && count == 6'd55) state_next = ERR;
        else if (bus.byte_stop)             state_next = PAD;
      end
      PAD:     state_next = ROUNDS;
      ROUNDS:  if (rnd == 6'd63) state_next = FINAL;
      FINAL:   state_next = DONE;
      DONE:    state_next = DONE;
      ERR:     state_next = ERR;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count   <= '0;
      rnd     <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < 55; i++) msg_buf[i] <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (bus.byte_rdy) begin
            if (count == 6'd55) begin
              ovf_q <= 1'b1;
            end else begin
              msg_buf[count] <= bus.data_in;
              count          <= count + 6'd1;
            end
          end
        end
        PAD: begin
          w   <= blk;
          rnd <= '0;
          {a, b, c, d, e, f, g, h} <= {h_init[0], h_init[1], h_init[2], h_init[3],
                                       h_init[4], h_init[5], h_init[6], h_init[7]};
        end
        ROUNDS: begin
          h <= g;
          g <= f;
          f <= e;
          e <= d + t1;
          d <= c;
          c <= b;
          b <= a;
          a <= t1 + t2;
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_next;
          rnd   <= rnd + 6'd1;
        end
        FINAL: begin
          out_q <= {h_init[0] + a, h_init[1] + b, h_init[2] + c, h_init[3] + d,
                    h_init[4] + e, h_init[5] + f, h_init[6] + g, h_init[7] + h};
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_main.sv
module tb_sha256_main;

  localparam logic [255:0] dig_abc   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] dig_empty = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [255:0] exp_q [$];

  sha256_main_if bus_if ();

  sha256_main dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_if.byte_rdy  = 1'b0;
    bus_if.byte_stop = 1'b0;
    bus_if.data_in   = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    bus_if.byte_rdy = 1'b1;
    bus_if.data_in  = v;
    tick();
    idle_inputs();
  endtask

  // byte_stop sampled at the next edge; expected digest queued now.
  task automatic send_stop(input logic [255:0] exp);
    exp_q.push_back(exp);
    bus_if.byte_stop = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic wait_digest(input string tag);
    int n;
    bit zero_bad;
    logic [255:0] exp;
    n = 0;
    zero_bad = 1'b0;
    while (bus_if.o_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (bus_if.o_valid !== 1'b1 && bus_if.out !== '0) zero_bad = 1'b1;
    end
    check({tag, "_latency"}, 256'(n), 256'd66);
    check({tag, "_out_zero_while_busy"}, 256'(zero_bad), 256'd0);
    if (exp_q.size() == 0) begin
      exp = '0;
      check({tag, "_scoreboard_empty"}, 256'(exp_q.size()), 256'd1);
    end else begin
      exp = exp_q.pop_front();
    end
    check({tag, "_digest"}, bus_if.out, exp);
    check({tag, "_overflow"}, 256'(bus_if.overflow), 256'd0);
  endtask

  task automatic send_abc();
    bus_if.byte_rdy = 1'b1;
    bus_if.data_in  = 8'h61;
    tick();
    bus_if.data_in  = 8'h62;
    tick();
    bus_if.data_in  = 8'h63;
    tick();
    idle_inputs();
  endtask

  initial begin
    string s56;
    logic [255:0] held;
    bit bad;
    s56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

    // reset with unknown control inputs
    rst = 1'b0;
    bus_if.byte_rdy  = 1'bx;
    bus_if.byte_stop = 1'bx;
    bus_if.data_in   = 8'hxx;
    tick();
    tick();
    tick();
    check("reset_out", bus_if.out, '0);
    check("reset_valid", 256'(bus_if.o_valid), 256'd0);
    check("reset_overflow", 256'(bus_if.overflow), 256'd0);
    idle_inputs();
    rst = 1'b1;

    // "abc" on consecutive cycles
    send_abc();
    send_stop(dig_abc);
    wait_digest("abc");

    // inputs ignored once the digest is held
    held = bus_if.out;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus_if.byte_rdy  = 1'b1;
      bus_if.byte_stop = i[0];
      bus_if.data_in   = 8'(i * 37);
      tick();
      if (bus_if.out !== held || bus_if.o_valid !== 1'b1) bad = 1'b1;
    end
    idle_inputs();
    check("done_hold_bad", 256'(bad), 256'd0);
    check("done_out", bus_if.out, dig_abc);

    // empty message
    do_reset();
    check("reset2_out", bus_if.out, '0);
    check("reset2_valid", 256'(bus_if.o_valid), 256'd0);
    send_stop(dig_empty);
    wait_digest("empty");

    // 56-byte message overflows on the last byte
    do_reset();
    for (int i = 0; i < 55; i++) send_byte(s56[i]);
    check("ovf_after_55", 256'(bus_if.overflow), 256'd0);
    send_byte(s56[55]);
    check("ovf_after_56", 256'(bus_if.overflow), 256'd1);
    bus_if.byte_stop = 1'b1;
    tick();
    idle_inputs();
    bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus_if.o_valid !== 1'b0 || bus_if.out !== '0 || bus_if.overflow !== 1'b1) bad = 1'b1;
    end
    check("err_hold_bad", 256'(bad), 256'd0);
    check("err_out", bus_if.out, '0);

    // byte_stop together with the last byte
    do_reset();
    send_byte(8'h61);
    send_byte(8'h62);
    exp_q.push_back(dig_abc);
    bus_if.byte_rdy  = 1'b1;
    bus_if.byte_stop = 1'b1;
    bus_if.data_in   = 8'h63;
    tick();
    idle_inputs();
    wait_digest("abc_stop_with_byte");

    // reset during round 30, then a clean rerun
    do_reset();
    send_abc();
    send_stop(dig_abc);
    tick();
    for (int i = 0; i < 30; i++) tick();
    rst = 1'b0;
    tick();
    check("midreset_out", bus_if.out, '0);
    check("midreset_valid", 256'(bus_if.o_valid), 256'd0);
    void'(exp_q.pop_front());
    tick();
    rst = 1'b1;
    send_abc();
    send_stop(dig_abc);
    wait_digest("abc_after_abort");

    check("scoreboard_drained", 256'(exp_q.size()), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
